// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, parameter defaults
// and a small constant helper used for counter sizing.
package rst_seq_pkg;

  localparam int RST_SEQ_HOLD_CYCLES_DEF    = 16;
  localparam int RST_SEQ_TIMEOUT_CYCLES_DEF = 1024;

  localparam logic [1:0] ST_HOLD_ALL   = 2'd0;
  localparam logic [1:0] ST_GAP        = 2'd1;
  localparam logic [1:0] ST_WAIT_READY = 2'd2;
  localparam logic [1:0] ST_RUN        = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_counter.sv
// Shared cycle counter for hold, gap and timeout intervals: synchronous clear, enable,
// saturating at all-ones, terminal count flagged when the count equals limit_i.
module rst_seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_STAGES downstream resets in order, each after a gap and once the previous
// domain reports ready. Define RST_SEQ_TIMEOUT_EN to bound each ready wait with a timeout.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES       = 3,
  parameter int HOLD_CYCLES    = RST_SEQ_HOLD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = RST_SEQ_TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_reset,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                timeout_err
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGES - 1);

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]       cnt_lim;
  logic                advance;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES - 1);
  logic err_q, err_d;
  assign cnt_lim = (state_q == ST_WAIT_READY) ? TO_LIM : HOLD_LIM;
`else
  assign cnt_lim = HOLD_LIM;
`endif

  rst_seq_counter #(.WIDTH(CW)) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (cnt_lim),
    .tc_o    (cnt_tc)
  );

  // req_reset wins over everything, so a ready arriving in the same cycle is dropped.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    advance     = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    err_d       = err_q;
`endif
    if (req_reset) begin
      state_d     = ST_HOLD_ALL;
      idx_d       = '0;
      stage_rst_d = '1;
      cnt_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD_ALL, ST_GAP: begin
          if (cnt_tc) begin
            stage_rst_d[idx_q] = 1'b0;
            state_d            = ST_WAIT_READY;
            cnt_clr            = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_WAIT_READY: begin
          advance = stage_ready[idx_q];
`ifdef RST_SEQ_TIMEOUT_EN
          if (!advance && cnt_tc) begin
            advance = 1'b1;
            err_d   = 1'b1;
          end
          cnt_en = !advance;
`endif
          if (advance) begin
            cnt_clr = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = ST_GAP;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    done_d = (state_d == ST_RUN);
    busy_d = !done_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD_ALL;
      idx_q       <= '0;
      stage_rst_q <= '1;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  // The error flag is sticky across req_reset; only reset_n clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign stage_rst = stage_rst_q;
  assign seq_done  = done_q;
  assign seq_busy  = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with N_STAGES=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=8;
// timeout expectations follow RST_SEQ_TIMEOUT_EN.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_reset;
  logic [2:0] stage_ready;
  logic [2:0] stage_rst;
  logic       seq_busy;
  logic       seq_done;
  logic       timeout_err;

  int totalChecks = 0;
  int badChecks   = 0;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int READY_DELAY = 6;
`else
  localparam int READY_DELAY = 10;
`endif

  reset_sequencer #(
    .N_STAGES       (3),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_reset   (req_reset),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rstN, input logic req, input logic [2:0] ready);
    reset_n     = rstN;
    req_reset   = req;
    stage_ready = ready;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] expRst,
                             input logic expDone, input logic expErr);
    totalChecks++;
    assert (stage_rst === expRst) else begin
      badChecks++;
      $error("[TB] FAIL %s stage_rst observed=%b expected=%b", tag, stage_rst, expRst);
    end
    totalChecks++;
    assert (seq_done === expDone) else begin
      badChecks++;
      $error("[TB] FAIL %s seq_done observed=%b expected=%b", tag, seq_done, expDone);
    end
    totalChecks++;
    assert (seq_busy === !expDone) else begin
      badChecks++;
      $error("[TB] FAIL %s seq_busy observed=%b expected=%b", tag, seq_busy, !expDone);
    end
    totalChecks++;
    assert (timeout_err === expErr) else begin
      badChecks++;
      $error("[TB] FAIL %s timeout_err observed=%b expected=%b", tag, timeout_err, expErr);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 3'b111);
    #2;
    applyStimulus(1'b0, 1'b0, 3'b111);
    #1;
    checkOutput("reset_async", 3'b111, 1'b0, 1'b0);
    tick(2);
    checkOutput("reset_held", 3'b111, 1'b0, 1'b0);

    $display("[TB] power-on sequence, all stages ready");
    applyStimulus(1'b1, 1'b0, 3'b111);
    tick(3);  checkOutput("hold_3", 3'b111, 1'b0, 1'b0);
    tick(1);  checkOutput("rel0", 3'b110, 1'b0, 1'b0);
    tick(4);  checkOutput("gap1_end", 3'b110, 1'b0, 1'b0);
    tick(1);  checkOutput("rel1", 3'b100, 1'b0, 1'b0);
    tick(4);  checkOutput("gap2_end", 3'b100, 1'b0, 1'b0);
    tick(1);  checkOutput("rel2", 3'b000, 1'b0, 1'b0);
    tick(1);  checkOutput("run", 3'b000, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b0, 3'b000);
    tick(3);  checkOutput("run_ignores_ready", 3'b000, 1'b1, 1'b0);

    $display("[TB] restart from RUN with 3-cycle req_reset");
    applyStimulus(1'b1, 1'b1, 3'b000);
    tick(1);  checkOutput("restart_edge", 3'b111, 1'b0, 1'b0);
    tick(2);  checkOutput("restart_held", 3'b111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b110);
    tick(3);  checkOutput("restart_hold3", 3'b111, 1'b0, 1'b0);
    tick(1);  checkOutput("restart_rel0", 3'b110, 1'b0, 1'b0);
    tick(6);  checkOutput("ignore_unreleased", 3'b110, 1'b0, 1'b0);

    $display("[TB] delayed ready on stage 1");
    applyStimulus(1'b1, 1'b0, 3'b001);
    tick(4);  checkOutput("dly_gap1", 3'b110, 1'b0, 1'b0);
    tick(1);  checkOutput("dly_rel1", 3'b100, 1'b0, 1'b0);
    tick(READY_DELAY); checkOutput("dly_waiting", 3'b100, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b011);
    tick(4);  checkOutput("dly_gap2", 3'b100, 1'b0, 1'b0);
    tick(1);  checkOutput("dly_rel2", 3'b000, 1'b0, 1'b0);
    tick(2);  checkOutput("dly_wait2", 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b111);
    tick(1);  checkOutput("dly_run", 3'b000, 1'b1, 1'b0);

    $display("[TB] mid-sequence restart in GAP(1)");
    applyStimulus(1'b1, 1'b1, 3'b000);
    tick(1);  checkOutput("mid_pre_restart", 3'b111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001);
    tick(4);  checkOutput("mid_rel0", 3'b110, 1'b0, 1'b0);
    tick(1);  checkOutput("mid_in_gap1", 3'b110, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000);
    tick(1);  checkOutput("mid_gap1_b", 3'b110, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b001);
    tick(1);  checkOutput("mid_restart", 3'b111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b111);
    tick(3);  checkOutput("mid_hold3", 3'b111, 1'b0, 1'b0);
    tick(1);  checkOutput("mid_rel0_again", 3'b110, 1'b0, 1'b0);

    $display("[TB] stage 1 never ready");
    applyStimulus(1'b1, 1'b0, 3'b101);
    tick(4);  checkOutput("to_gap1", 3'b110, 1'b0, 1'b0);
    tick(1);  checkOutput("to_rel1", 3'b100, 1'b0, 1'b0);
`ifdef RST_SEQ_TIMEOUT_EN
    tick(7);  checkOutput("to_before", 3'b100, 1'b0, 1'b0);
    tick(1);  checkOutput("to_fire", 3'b100, 1'b0, 1'b1);
    tick(3);  checkOutput("to_gap2", 3'b100, 1'b0, 1'b1);
    tick(1);  checkOutput("to_rel2", 3'b000, 1'b0, 1'b1);
    tick(1);  checkOutput("to_run", 3'b000, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b101);
    tick(1);  checkOutput("to_sticky_req", 3'b111, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b101);
    tick(2);  checkOutput("to_sticky_after", 3'b111, 1'b0, 1'b1);
`else
    tick(110); checkOutput("nto_stuck", 3'b100, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b111);
    tick(4);  checkOutput("nto_gap2", 3'b100, 1'b0, 1'b0);
    tick(1);  checkOutput("nto_rel2", 3'b000, 1'b0, 1'b0);
    tick(1);  checkOutput("nto_run", 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b111);
    tick(1);  checkOutput("nto_req", 3'b111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b111);
    tick(2);  checkOutput("nto_after", 3'b111, 1'b0, 1'b0);
`endif

    applyStimulus(1'b0, 1'b0, 3'b111);
    #1;
    checkOutput("final_reset", 3'b111, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
